// File: rtl/dmem_store_buffer_if.sv
// Core data-memory port plus RAM write/read port of the posted-write store buffer.
// slave = the buffer, master = core/RAM side.
interface dmem_store_buffer_if #(
  parameter int unsigned WORD_BITWIDTH = 32,
  parameter int unsigned ADDR_BITWIDTH = 32,
  parameter int unsigned DEPTH         = 4
);
  localparam int unsigned CountW = $clog2(DEPTH) + 1;

  logic                     data_ce_i;
  logic                     data_we_i;
  logic [ADDR_BITWIDTH-1:0] data_addr_i;
  logic [WORD_BITWIDTH-1:0] data_i;
  logic [WORD_BITWIDTH-1:0] data_o;
  logic                     stall_o;
  logic [ADDR_BITWIDTH-1:0] mem_rd_addr_o;
  logic [WORD_BITWIDTH-1:0] mem_rd_data_i;
  logic                     mem_wr_valid_o;
  logic                     mem_wr_ready_i;
  logic [ADDR_BITWIDTH-1:0] mem_wr_addr_o;
  logic [WORD_BITWIDTH-1:0] mem_wr_data_o;
  logic [CountW-1:0]        count_o;
  logic                     empty_o;

  modport slave (
    input  data_ce_i, data_we_i, data_addr_i, data_i, mem_rd_data_i, mem_wr_ready_i,
    output data_o, stall_o, mem_rd_addr_o, mem_wr_valid_o, mem_wr_addr_o, mem_wr_data_o,
    output count_o, empty_o
  );

  modport master (
    output data_ce_i, data_we_i, data_addr_i, data_i, mem_rd_data_i, mem_wr_ready_i,
    input  data_o, stall_o, mem_rd_addr_o, mem_wr_valid_o, mem_wr_addr_o, mem_wr_data_o,
    input  count_o, empty_o
  );
endinterface

// File: rtl/dmem_store_buffer.sv
// Posted-write store buffer: stores retire into a FIFO and drain in order to the RAM.
// STORE_BUF_FWD_EN enables load forwarding from buffered stores; otherwise a load hit stalls.
module dmem_store_buffer #(
  parameter int unsigned WORD_BITWIDTH = 32,
  parameter int unsigned ADDR_BITWIDTH = 32,
  parameter int unsigned DEPTH         = 4
) (
  input logic                clk,
  input logic                rst,
  dmem_store_buffer_if.slave bus
);
  localparam int unsigned PtrW   = $clog2(DEPTH);
  localparam int unsigned CountW = $clog2(DEPTH) + 1;

  logic [PtrW-1:0]          wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]          rd_ptr_q, rd_ptr_d;
  logic [CountW-1:0]        count_q, count_d;
  logic [ADDR_BITWIDTH-1:0] addr_q  [DEPTH];
  logic [ADDR_BITWIDTH-1:0] addr_d  [DEPTH];
  logic [WORD_BITWIDTH-1:0] wdata_q [DEPTH];
  logic [WORD_BITWIDTH-1:0] wdata_d [DEPTH];

  logic full, push, pop, load, store, hit;
  logic [PtrW-1:0] idx;
`ifdef STORE_BUF_FWD_EN
  logic [WORD_BITWIDTH-1:0] hit_data;
`endif

  always_comb begin
    full  = (count_q == CountW'(DEPTH));
    store = bus.data_ce_i & bus.data_we_i;
    load  = bus.data_ce_i & ~bus.data_we_i;
    push  = store & ~full;
    pop   = (count_q != '0) & bus.mem_wr_ready_i;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    if (push) begin
      addr_d[wr_ptr_q]  = bus.data_addr_i;
      wdata_d[wr_ptr_q] = bus.data_i;
      wr_ptr_d          = wr_ptr_q + PtrW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
    end
    if (push && !pop) begin
      count_d = count_q + CountW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CountW'(1);
    end
  end

  // Walk oldest to youngest so the last match found is the youngest.
  always_comb begin
    hit = 1'b0;
    idx = '0;
`ifdef STORE_BUF_FWD_EN
    hit_data = '0;
`endif
    for (int k = 0; k < DEPTH; k++) begin
      idx = rd_ptr_q + PtrW'(k);
      if ((CountW'(k) < count_q) &&
          (addr_q[idx][ADDR_BITWIDTH-1:2] == bus.data_addr_i[ADDR_BITWIDTH-1:2])) begin
        hit = 1'b1;
`ifdef STORE_BUF_FWD_EN
        hit_data = wdata_q[idx];
`endif
      end
    end
  end

  always_comb begin
    bus.mem_rd_addr_o  = bus.data_addr_i;
    bus.mem_wr_valid_o = (count_q != '0);
    bus.mem_wr_addr_o  = addr_q[rd_ptr_q];
    bus.mem_wr_data_o  = wdata_q[rd_ptr_q];
    bus.count_o        = count_q;
    bus.empty_o        = (count_q == '0);
`ifdef STORE_BUF_FWD_EN
    bus.stall_o = store & full;
    bus.data_o  = (load && hit) ? hit_data : bus.mem_rd_data_i;
`else
    bus.stall_o = (store & full) | (load & hit);
    bus.data_o  = bus.mem_rd_data_i;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage carries no reset; occupancy alone decides validity.
  always_ff @(posedge clk) begin
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
  end
endmodule
